led_pulse_driver: RTL and testbench



---
 rtl/led_pulse_driver_pkg.sv | 27 ++
 rtl/led_pulse_driver_if.sv | 18 +
 rtl/led_pulse_driver_tick_gen.sv | 26 ++
 rtl/led_pulse_driver.sv | 130 +++++++++++++
 tb/tb_led_pulse_driver.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pulse_driver_pkg.sv
// Shared cape LED definitions.
//   LED_OFF/LED_ON/LED_BLINK/LED_PULSE : command mode encodings
//   DEFAULT_TICK_DIV                    : clk cycles per 1 ms tick at 50 MHz
//   led_state_t                         : request FSM state
//   state_level()                       : desired LED level for a state
package led_pulse_driver_pkg;

    localparam logic [1:0] LED_OFF   = 2'd0;
    localparam logic [1:0] LED_ON    = 2'd1;
    localparam logic [1:0] LED_BLINK = 2'd2;
    localparam logic [1:0] LED_PULSE = 2'd3;

    localparam int unsigned DEFAULT_TICK_DIV = 50000;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_ON,
        ST_BLINK_HI,
        ST_BLINK_LO,
        ST_PULSE
    } led_state_t;

    function automatic logic state_level(input led_state_t s);
        return (s == ST_ON) || (s == ST_BLINK_HI) || (s == ST_PULSE);
    endfunction

endpackage

// File: rtl/led_pulse_driver_if.sv
// Command/status bundle between the register block and one LED driver.
//   mode         : 0=off 1=on 2=blink 3=pulse
//   period_ticks : blink half-period / pulse length in ticks
//   trigger      : single-cycle pulse start
//   led_out      : registered LED drive, active high
//   busy         : pulse running or a deferred edge pending
interface led_pulse_driver_if #(
    parameter int unsigned PERIOD_W = 16
);
    logic [1:0]          mode;
    logic [PERIOD_W-1:0] period_ticks;
    logic                trigger;
    logic                led_out;
    logic                busy;

    modport master (output mode, period_ticks, trigger, input led_out, busy);
    modport slave  (input mode, period_ticks, trigger, output led_out, busy);
endinterface

// File: rtl/led_pulse_driver_tick_gen.sv
// Free-running time-base: tick is high for one clk every TICK_DIV clks.
//   clk    : system clock
//   resetn : async active-low reset
//   tick   : one-clk strobe when the divider reaches TICK_DIV-1
module tick_gen
    import led_pulse_driver_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
)(
    input  logic clk,
    input  logic resetn,
    output logic tick
);
    localparam int unsigned       CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)           cnt_q <= '0;
        else if (cnt_q == LAST) cnt_q <= '0;
        else                   cnt_q <= cnt_q + 1'b1;
    end

    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/led_pulse_driver.sv
// Drives one cape LED from a register-level command (off/on/blink/pulse)
// and guarantees a minimum hold time between output edges.
//   clk    : system clock
//   resetn : async active-low reset
//   bus    : led_pulse_driver_if.slave (mode, period_ticks, trigger in;
//            led_out, busy out)
module led_pulse_driver
    import led_pulse_driver_pkg::*;
#(
    parameter int unsigned TICK_DIV       = DEFAULT_TICK_DIV,
    parameter int unsigned MIN_HOLD_TICKS = 20,
    parameter int unsigned PERIOD_W       = 16
)(
    input  logic              clk,
    input  logic              resetn,
    led_pulse_driver_if.slave bus
);
    localparam int unsigned         HOLD_W    = (MIN_HOLD_TICKS > 0) ? $clog2(MIN_HOLD_TICKS + 1) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(MIN_HOLD_TICKS);
    // Blink half-periods shorter than the hold window would be swallowed by
    // the guard, so the blink counter never loads less than the hold length.
    localparam logic [PERIOD_W-1:0] BLINK_MIN = PERIOD_W'((MIN_HOLD_TICKS > 1) ? MIN_HOLD_TICKS : 1);

    logic                tick;
    led_state_t          state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] pulse_load, blink_load;
    logic [HOLD_W-1:0]   hold_q;
    logic                led_q;
    logic                req;
    logic                mode_changed;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .tick   (tick)
    );

    assign pulse_load = (bus.period_ticks == '0) ? PERIOD_W'(1) : bus.period_ticks;
    assign blink_load = (bus.period_ticks < BLINK_MIN) ? BLINK_MIN : bus.period_ticks;

    // A mode that does not match the current state forces a transition.
    // OFF is the resting state for both mode 0 and mode 3 (armed, no pulse).
    always_comb begin
        mode_changed = 1'b0;
        case (state_q)
            ST_OFF:                   mode_changed = (bus.mode == LED_ON) || (bus.mode == LED_BLINK);
            ST_ON:                    mode_changed = (bus.mode != LED_ON);
            ST_BLINK_HI, ST_BLINK_LO: mode_changed = (bus.mode != LED_BLINK);
            ST_PULSE:                 mode_changed = (bus.mode != LED_PULSE);
            default:                  mode_changed = 1'b1;
        endcase
    end

    // Request FSM. Loads take priority over tick decrements in every branch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mode_changed) begin
            case (bus.mode)
                LED_ON:    begin state_d = ST_ON;       cnt_d = '0;         end
                LED_BLINK: begin state_d = ST_BLINK_HI; cnt_d = blink_load; end
                default:   begin state_d = ST_OFF;      cnt_d = '0;         end
            endcase
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (bus.mode == LED_PULSE && bus.trigger) begin
                        state_d = ST_PULSE;
                        cnt_d   = pulse_load;
                    end
                end
                ST_BLINK_HI, ST_BLINK_LO: begin
                    if (tick) begin
                        if (cnt_q <= PERIOD_W'(1)) begin
                            state_d = (state_q == ST_BLINK_HI) ? ST_BLINK_LO : ST_BLINK_HI;
                            cnt_d   = blink_load;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                ST_PULSE: begin
                    if (bus.trigger) begin
                        cnt_d = pulse_load;          // retrigger extends the pulse
                    end else if (tick) begin
                        if (cnt_q <= PERIOD_W'(1)) begin
                            state_d = ST_OFF;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req = state_level(state_q);

    // Hold guard: the output only follows req once the hold has run out, so
    // toggles inside the window collapse into the last requested level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_q <= '0;
            led_q  <= 1'b0;
        end else if (hold_q == '0) begin
            if (led_q != req) begin
                led_q  <= req;
                hold_q <= HOLD_LOAD;
            end
        end else if (tick) begin
            hold_q <= hold_q - 1'b1;
        end
    end

    assign bus.led_out = led_q;
    assign bus.busy    = (state_q == ST_PULSE) || ((hold_q != '0) && (led_q != req));
endmodule

// File: tb/tb_led_pulse_driver.sv
// Directed bench for led_pulse_driver (TICK_DIV=4, MIN_HOLD_TICKS=2).
// Each stimulus step pushes the led_out edges it should cause (level and
// absolute cycle) onto a queue; a monitor pops and compares every edge.
module tb_led_pulse_driver;
    import led_pulse_driver_pkg::*;

    localparam int TDIV = 4;
    localparam int HOLD = 2;
    localparam int PW   = 8;

    typedef struct {
        string tag;
        logic  lvl;
        int    at;
    } edge_t;

    logic  clk    = 1'b0;
    logic  resetn = 1'b0;
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;
    logic  prev_led = 1'b0;
    edge_t exp_q[$];

    led_pulse_driver_if #(.PERIOD_W(PW)) bus ();

    led_pulse_driver #(
        .TICK_DIV       (TDIV),
        .MIN_HOLD_TICKS (HOLD),
        .PERIOD_W       (PW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Cycle count since reset release; tick edges are where cyc becomes a multiple of TDIV.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_edge(input string tag, input logic lvl, input int at);
        exp_q.push_back('{tag, lvl, at});
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            prev_led = 1'b0;
        end else if (bus.led_out !== prev_led) begin
            edge_t e;
            prev_led = bus.led_out;
            chk("edge_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, "_lvl"}, int'(bus.led_out), int'(e.lvl));
                chk({e.tag, "_cyc"}, cyc, e.at);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stop on the negedge just before a tick edge.
    task automatic sync_tick();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((cyc % TDIV) != TDIV - 1 && g < 16);
    endtask

    task automatic wait_until(input int target);
        int g = 0;
        while (cyc < target && g < 1000) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bus.mode         = LED_OFF;
        bus.period_ticks = '0;
        bus.trigger      = 1'b0;

        // Reset state
        step(3);
        chk("rst_led", int'(bus.led_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        resetn = 1'b1;

        // Reset mid-blink (period 1 clamps to 2 ticks, so first fall is far away)
        sync_tick();
        c = cyc;
        bus.period_ticks = 8'd1;
        bus.mode         = LED_BLINK;
        expect_edge("blink_pre_rst_rise", 1'b1, c + 2);
        drain("pre_rst");
        wait_until(c + 6);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_led", int'(bus.led_out), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        bus.mode = LED_OFF;
        step(2);
        resetn = 1'b1;
        step(10);
        chk("post_rst_led", int'(bus.led_out), 0);
        chk("post_rst_busy", int'(bus.busy), 0);

        // Steady on: FSM takes the mode at edge 1, led follows req at edge 2
        c = cyc;
        bus.mode = LED_ON;
        expect_edge("on_rise", 1'b1, c + 2);
        drain("on");
        step(20);
        chk("on_hold_led", int'(bus.led_out), 1);
        chk("on_busy", int'(bus.busy), 0);

        // Blink period 3: toggles every 12 clk
        sync_tick();
        c = cyc;
        bus.period_ticks = 8'd3;
        bus.mode         = LED_BLINK;
        expect_edge("blink3_fall1", 1'b0, c + 14);
        expect_edge("blink3_rise",  1'b1, c + 26);
        expect_edge("blink3_fall2", 1'b0, c + 38);
        wait_until(c + 40);
        // Period 0 takes effect at the next reload: toggles every 8 clk
        bus.period_ticks = 8'd0;
        expect_edge("blink0_rise1", 1'b1, c + 50);
        expect_edge("blink0_fall",  1'b0, c + 58);
        expect_edge("blink0_rise2", 1'b1, c + 66);
        wait_until(c + 68);
        bus.mode = LED_OFF;
        expect_edge("blink_stop_fall", 1'b0, c + 74);
        step(2);
        chk("blink_stop_busy", int'(bus.busy), 1);
        drain("blink");

        // Hold deferral: 1 -> 0 -> 1 inside one tick gives a single rise
        step(12);
        sync_tick();
        c = cyc;
        bus.mode = LED_ON;
        expect_edge("defer_rise", 1'b1, c + 2);
        wait_until(c + 2);
        bus.mode = LED_OFF;
        step(1);
        chk("defer_drop_busy", int'(bus.busy), 1);
        bus.mode = LED_ON;
        step(1);
        chk("defer_back_busy", int'(bus.busy), 0);
        wait_until(c + 6);
        chk("defer_still_on", int'(bus.led_out), 1);
        bus.mode = LED_OFF;
        expect_edge("defer_fall", 1'b0, c + 10);
        step(2);
        chk("defer_fall_busy", int'(bus.busy), 1);
        drain("defer");

        // Pulse, 5 ticks, started on a tick edge: exactly 20 clk high
        step(12);
        sync_tick();
        c = cyc;
        bus.period_ticks = 8'd5;
        bus.mode         = LED_PULSE;
        bus.trigger      = 1'b1;
        expect_edge("pulse_rise", 1'b1, c + 2);
        expect_edge("pulse_fall", 1'b0, c + 22);
        step(1);
        bus.trigger = 1'b0;
        wait_until(c + 10);
        chk("pulse_busy_mid", int'(bus.busy), 1);
        wait_until(c + 20);
        chk("pulse_busy_late", int'(bus.busy), 1);
        drain("pulse");
        step(1);
        chk("pulse_end_busy", int'(bus.busy), 0);

        // Retrigger on the 3rd tick: ends 5 ticks after the retrigger
        step(12);
        sync_tick();
        c = cyc;
        bus.trigger = 1'b1;
        expect_edge("retrig_rise", 1'b1, c + 2);
        expect_edge("retrig_fall", 1'b0, c + 34);
        step(1);
        bus.trigger = 1'b0;
        wait_until(c + 12);
        bus.trigger = 1'b1;
        step(1);
        bus.trigger = 1'b0;
        wait_until(c + 30);
        chk("retrig_extended", int'(bus.led_out), 1);
        drain("retrig");

        // Abort: mode 3 -> 0 during a pulse, fall deferred by the hold
        step(12);
        sync_tick();
        c = cyc;
        bus.trigger = 1'b1;
        expect_edge("abort_rise", 1'b1, c + 2);
        expect_edge("abort_fall", 1'b0, c + 10);
        step(1);
        bus.trigger = 1'b0;
        wait_until(c + 2);
        bus.mode = LED_OFF;
        step(1);
        chk("abort_busy_early", int'(bus.busy), 1);
        wait_until(c + 8);
        chk("abort_busy_late", int'(bus.busy), 1);
        chk("abort_led_held", int'(bus.led_out), 1);
        drain("abort");
        step(1);
        chk("abort_end_busy", int'(bus.busy), 0);
        chk("abort_end_led", int'(bus.led_out), 0);

        step(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
